// File: rtl/tracking_fifo_sc.sv
// Single-clock WIDTH x 2^ADDR_BITS FIFO with address, fill-level, threshold and
// sticky error reporting. Read data is registered with one cycle of latency.
module tracking_fifo_sc #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 11,
  parameter int AF_LEVEL  = 2040,
  parameter int AE_LEVEL  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 write_in,
  input  logic                 read_out,
  input  logic                 clear_err,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic [ADDR_BITS-1:0] addr_in,
  output logic [ADDR_BITS-1:0] addr_out,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int              DEPTH   = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_L    = (ADDR_BITS+1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] AE_L    = (ADDR_BITS+1)'(AE_LEVEL);
  localparam logic [ADDR_BITS:0] ONE     = (ADDR_BITS+1)'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [WIDTH-1:0]   r_data_out;
  logic               r_valid;
  logic [ADDR_BITS:0] r_wr_ptr;
  logic [ADDR_BITS:0] r_rd_ptr;
  logic [ADDR_BITS:0] r_count;
  logic               r_full;
  logic               r_empty;
  logic               r_afull;
  logic               r_aempty;
  logic               r_ovf;
  logic               r_unf;

  logic               w_rd_ok;
  logic               w_wr_ok;
  logic [ADDR_BITS:0] w_count_next;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_ok = read_out & ~r_empty;
  assign w_wr_ok = write_in & (~r_full | w_rd_ok);

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_next = r_count + ONE;
      2'b01:   w_count_next = r_count - ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Storage is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + ONE;
      end
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + ONE;
        r_data_out <= r_mem[r_rd_ptr[ADDR_BITS-1:0]];
      end
      r_valid  <= w_rd_ok;
      r_count  <= w_count_next;
      r_full   <= (w_count_next == DEPTH_L);
      r_empty  <= (w_count_next == '0);
      r_afull  <= (w_count_next >= AF_L);
      r_aempty <= (w_count_next <= AE_L);
      // A fresh error outranks clear_err in the same cycle.
      r_ovf    <= (r_ovf & ~clear_err) | (write_in & ~w_wr_ok);
      r_unf    <= (r_unf & ~clear_err) | (read_out & ~w_rd_ok);
    end
  end

  assign data_out     = r_data_out;
  assign valid_out    = r_valid;
  assign addr_in      = r_wr_ptr[ADDR_BITS-1:0];
  assign addr_out     = r_rd_ptr[ADDR_BITS-1:0];
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_tracking_fifo_sc.sv
// Bench for tracking_fifo_sc: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the FIFO.
module tb_tracking_fifo_sc;

  localparam int WIDTH = 8;
  localparam int AB    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic            clk = 1'b0;
  logic            reset, write_in, read_out, clear_err;
  logic [WIDTH-1:0] data_in, data_out;
  logic            valid_out, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AB-1:0]   addr_in, addr_out;
  logic [AB:0]     count;

  always #5 clk = ~clk;

  tracking_fifo_sc #(.WIDTH(WIDTH), .ADDR_BITS(AB), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .read_out(read_out), .clear_err(clear_err), .data_out(data_out),
    .valid_out(valid_out), .addr_in(addr_in), .addr_out(addr_out), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [7:0] q[$];
  int         n_wr, n_rd;
  logic [7:0] m_data;
  logic       m_valid, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic w, input logic [7:0] d,
                      input logic r, input logic c);
    bit full_m, empty_m, rd_ok, wr_ok;
    reset = rst; write_in = w; data_in = d; read_out = r; clear_err = c;
    if (rst) begin
      q.delete(); n_wr = 0; n_rd = 0; m_data = 8'h00; m_valid = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      full_m  = (q.size() == DEPTH);
      empty_m = (q.size() == 0);
      rd_ok   = r && !empty_m;
      wr_ok   = w && (!full_m || rd_ok);
      m_valid = rd_ok;
      if (rd_ok) begin m_data = q.pop_front(); n_rd++; end
      if (wr_ok) begin q.push_back(d); n_wr++; end
      m_ovf = (m_ovf && !c) || (w && !wr_ok);
      m_unf = (m_unf && !c) || (r && !rd_ok);
    end
    @(posedge clk);
    #1;
    chk({tag, ".data"},  32'(data_out),     32'(m_data));
    chk({tag, ".valid"}, 32'(valid_out),    32'(m_valid));
    chk({tag, ".ain"},   32'(addr_in),      32'(n_wr % DEPTH));
    chk({tag, ".aout"},  32'(addr_out),     32'(n_rd % DEPTH));
    chk({tag, ".count"}, 32'(count),        32'(q.size()));
    chk({tag, ".full"},  32'(full),         32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty),        32'(q.size() == 0));
    chk({tag, ".af"},    32'(almost_full),  32'(q.size() >= AF));
    chk({tag, ".ae"},    32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, ".ovf"},   32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},   32'(underflow),    32'(m_unf));
    $display("%s rst=%0b w=%0b d=%02h r=%0b c=%0b -> dout=%02h v=%0b cnt=%0d ain=%0d aout=%0d ovf=%0b unf=%0b",
             tag, rst, w, d, r, c, data_out, valid_out, count, addr_in, addr_out, overflow, underflow);
  endtask

  initial begin
    reset = 1'b1; write_in = 1'b0; read_out = 1'b0; clear_err = 1'b0; data_in = '0;
    step("rst", 1, 0, 8'h00, 0, 0);
    step("rst", 1, 0, 8'h00, 0, 0);

    // 1: fill then drain
    for (int i = 0; i < 8; i++) step("t1w", 0, 1, 8'(8'h11 + i), 0, 0);
    for (int i = 0; i < 8; i++) step("t1r", 0, 0, 8'h00, 1, 0);
    step("t1idle", 0, 0, 8'h00, 0, 0);

    // 2: overflow while full, then clear
    for (int i = 0; i < 8; i++) step("t2w", 0, 1, 8'(8'h20 + i), 0, 0);
    step("t2ovf", 0, 1, 8'h99, 0, 0);
    step("t2clr", 0, 0, 8'h00, 0, 1);
    // clear_err together with a new overflow keeps the flag set
    step("t2ovf2", 0, 1, 8'h9a, 0, 1);
    step("t2clr2", 0, 0, 8'h00, 0, 1);

    // 4: full with read+write together
    step("t4rw", 0, 1, 8'h55, 1, 0);
    for (int i = 0; i < 8; i++) step("t4r", 0, 0, 8'h00, 1, 0);

    // 3: empty with read+write together
    step("t3rw", 0, 1, 8'h42, 1, 0);
    step("t3r", 0, 0, 8'h00, 1, 1);
    step("t3idle", 0, 0, 8'h00, 0, 0);

    // 5: stream 20 words with interleaved reads
    for (int i = 0; i < 20; i++) step("t5", 0, 1, 8'(8'h60 + i), (i % 3) != 0, 0);
    while (q.size() != 0) step("t5drain", 0, 0, 8'h00, 1, 0);

    // 6: reset with count=5 and a read in flight
    for (int i = 0; i < 6; i++) step("t6w", 0, 1, 8'(8'hA0 + i), 0, 0);
    step("t6ovf", 0, 0, 8'h00, 1, 0);
    step("t6rst", 1, 0, 8'h00, 0, 0);
    step("t6post", 0, 0, 8'h00, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic w, r, c, rs;
      w  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 65 : 35));
      r  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 65));
      c  = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 127) == 0);
      step("rnd", rs, w, 8'($urandom), r, c);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
